// File: rtl/cpu_pkg.sv
// Shared constants and types for the ID/EX pipeline register.
package cpu_pkg;

    localparam int REGW     = 5;
    localparam int AOPW_DEF = 4;

    typedef logic [REGW-1:0] reg_idx_t;

    // Single-bit controls carried from decode into execute.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic alu_src;
        logic mem_to_reg;
    } ex_ctrl_t;

    // A bubble is an instruction with every side-effecting control cleared.
    localparam ex_ctrl_t CTRL_BUBBLE = '0;
    localparam reg_idx_t WREG_BUBBLE = '0;

    // What the pipeline register does on the coming edge (reset handled separately).
    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_STALL   = 2'd1,
        ACT_FLUSH   = 2'd2
    } ex_act_e;

    // r0 is hardwired to zero, so it never produces a dependency.
    function automatic logic idx_match(input reg_idx_t a, input reg_idx_t b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the instruction in EX and the one in ID.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic     ex_valid,
    input  logic     ex_mem_read,
    input  logic     ex_reg_write,
    input  reg_idx_t ex_wreg,
    input  logic     id_valid,
    input  reg_idx_t id_rs,
    input  reg_idx_t id_rt,
    output logic     stall
);

    // Stall while a load in EX targets a register the decoded instruction reads.
    always_comb begin
        stall = ex_valid & ex_mem_read & ex_reg_write & id_valid &
                (idx_match(ex_wreg, id_rs) | idx_match(ex_wreg, id_rt));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush, write-through bypass
// and a saturating count of inserted load-use bubbles.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AOPW = AOPW_DEF,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [DW-1:0]   id_pc,
    input  logic [DW-1:0]   id_rd1,
    input  logic [DW-1:0]   id_rd2,
    input  logic [DW-1:0]   id_imm,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic [4:0]      id_rd,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_alu_src,
    input  logic            id_reg_dst,
    input  logic            id_mem_to_reg,
    input  logic [AOPW-1:0] id_alu_op,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_wa,
    input  logic [DW-1:0]   wb_wd,
    input  logic            flush,
    output logic            ex_valid,
    output logic [DW-1:0]   ex_pc,
    output logic [DW-1:0]   ex_a,
    output logic [DW-1:0]   ex_b,
    output logic [DW-1:0]   ex_imm,
    output logic [4:0]      ex_rs,
    output logic [4:0]      ex_rt,
    output logic [4:0]      ex_wreg,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_alu_src,
    output logic            ex_mem_to_reg,
    output logic [AOPW-1:0] ex_alu_op,
    output logic            stall,
    output logic [CNTW-1:0] bubble_cnt
);

    logic            valid_q,  valid_d;
    logic [DW-1:0]   pc_q,     pc_d;
    logic [DW-1:0]   a_q,      a_d;
    logic [DW-1:0]   b_q,      b_d;
    logic [DW-1:0]   imm_q,    imm_d;
    reg_idx_t        rs_q,     rs_d;
    reg_idx_t        rt_q,     rt_d;
    reg_idx_t        wreg_q,   wreg_d;
    ex_ctrl_t        ctrl_q,   ctrl_d;
    logic [AOPW-1:0] alu_op_q, alu_op_d;
    logic [CNTW-1:0] cnt_q,    cnt_d;

    ex_act_e  act;
    ex_ctrl_t id_ctrl;
    logic     byp_a, byp_b;

    hazard_detect u_hazard (
        .ex_valid     (valid_q),
        .ex_mem_read  (ctrl_q.mem_read),
        .ex_reg_write (ctrl_q.reg_write),
        .ex_wreg      (wreg_q),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .stall        (stall)
    );

    // Edge action, bypass selects and next-state for every pipeline field.
    always_comb begin
        if (flush)      act = ACT_FLUSH;
        else if (stall) act = ACT_STALL;
        else            act = ACT_CAPTURE;

        id_ctrl.reg_write  = id_reg_write;
        id_ctrl.mem_read   = id_mem_read;
        id_ctrl.mem_write  = id_mem_write;
        id_ctrl.alu_src    = id_alu_src;
        id_ctrl.mem_to_reg = id_mem_to_reg;

        // The register file is written this same edge; forward the value being written.
        byp_a = wb_reg_write & idx_match(wb_wa, id_rs);
        byp_b = wb_reg_write & idx_match(wb_wa, id_rt);

        valid_d  = 1'b0;
        pc_d     = pc_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        wreg_d   = WREG_BUBBLE;
        ctrl_d   = CTRL_BUBBLE;
        alu_op_d = '0;

        if (act == ACT_CAPTURE) begin
            valid_d = id_valid;
            pc_d    = id_pc;
            a_d     = byp_a ? wb_wd : id_rd1;
            b_d     = byp_b ? wb_wd : id_rd2;
            imm_d   = id_imm;
            rs_d    = id_rs;
            rt_d    = id_rt;
            if (id_valid) begin
                wreg_d   = id_reg_dst ? id_rd : id_rt;
                ctrl_d   = id_ctrl;
                alu_op_d = id_alu_op;
            end
        end

        // Only a genuine load-use bubble counts; a flush takes precedence.
        cnt_d = cnt_q;
        if ((act == ACT_STALL) && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            wreg_q   <= '0;
            ctrl_q   <= CTRL_BUBBLE;
            alu_op_q <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            wreg_q   <= wreg_d;
            ctrl_q   <= ctrl_d;
            alu_op_q <= alu_op_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_a          = a_q;
    assign ex_b          = b_q;
    assign ex_imm        = imm_q;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_wreg       = wreg_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_alu_op     = alu_op_q;
    assign bubble_cnt    = cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DW, default 32: datapath width for PC, register data and immediate.
REQ-002 SHALL have parameter AOPW, default 4: ALU opcode width.
REQ-003 SHALL have parameter CNTW, default 16: width of the stall bubble counter.
REQ-004 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports id_valid (in, 1), id_pc, id_rd1, id_rd2, id_imm (in, DW each): decode-stage instruction, register-file read data and sign-extended immediate.
REQ-007 SHALL have ports id_rs, id_rt, id_rd (in, 5 each): source and destination register indices.
REQ-008 SHALL have decode-control inputs id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst, id_mem_to_reg (in, 1 each) and id_alu_op (in, AOPW).
REQ-009 SHALL have ports wb_reg_write (in, 1), wb_wa (in, 5), wb_wd (in, DW): the write port currently driven into the register file.
REQ-010 SHALL have port flush, input, 1: branch/jump resolved taken in EX; kill the instruction in decode.
REQ-011 SHALL have registered outputs ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_wreg (5) and ex_* copies of every REQ-008 control, except reg_dst, which is consumed.
REQ-012 SHALL have port stall, output, 1, combinational: hold PC and IF/ID this cycle.
REQ-013 SHALL have port bubble_cnt, output, CNTW: count of load-use bubbles inserted.

Function
REQ-014 SHALL compute stall = ex_valid & ex_mem_read & ex_reg_write & (ex_wreg!=0) & id_valid & ((ex_wreg==id_rs) | (ex_wreg==id_rt)).
REQ-015 SHALL apply per-edge priority: rst > flush > stall > capture.
REQ-016 Capture SHALL latch all id_* fields into ex_*, with one-cycle latency.
REQ-017 On capture, ex_wreg SHALL be id_reg_dst ? id_rd : id_rt.
REQ-018 On capture, ex_a SHALL equal wb_wd when wb_reg_write & wb_wa!=0 & wb_wa==id_rs, and id_rd1 otherwise; ex_b SHALL use the same rule with id_rt and id_rd2 (same-cycle write-through bypass).
REQ-019 Flush or stall SHALL load a bubble: ex_valid=0, all ex_* controls 0, ex_wreg=0; data fields may hold any value.
REQ-020 id_valid=0 on a capture SHALL also produce a bubble.
REQ-021 bubble_cnt SHALL increment by 1 on each edge where stall=1 and flush=0, and saturate at 2^CNTW-1 (no wrap).
REQ-022 Flush coincident with stall SHALL produce a flush bubble without incrementing bubble_cnt; stall deasserts next cycle because ex_valid=0.
REQ-023 A register index of 0 SHALL never cause a stall or a bypass.

Reset
REQ-024 rst=1 at an edge SHALL clear every registered output, including bubble_cnt, to 0, with precedence over flush and stall.
REQ-025 stall SHALL be 0 during the cycle after reset because ex_valid=0.
REQ-026 Reset asserted mid-stall SHALL discard the pending stall.

Structure
REQ-027 Register-index width (5), AOPW default and the bubble control encoding SHALL live in the shared cpu_pkg constants package.
REQ-028 The stall equation SHALL be one combinational sub-module, hazard_detect; all state SHALL stay in id_ex_stage.

Verification
REQ-029 Reset: rst=1 for 2 cycles with id_valid=1 -> all ex_* = 0, bubble_cnt=0, stall=0.
REQ-030 Capture: id_pc=0x100, id_rd1=5, id_rd2=7, id_reg_dst=1, id_rd=9 -> next edge: ex_pc=0x100, ex_a=5, ex_b=7, ex_wreg=9, ex_valid=1.
REQ-031 Load-use: ex holds lw to r3 (ex_mem_read=1); id_rs=3 -> stall=1, next ex_valid=0, bubble_cnt=1; the following cycle stall=0 and the instruction is captured.
REQ-032 Bypass: wb_reg_write=1, wb_wa=4, wb_wd=0xDEAD, id_rt=4, id_rd2=0 -> ex_b=0xDEAD; repeating with wb_wa=0 -> ex_b=0.
REQ-033 Flush with stall: load-use condition plus flush=1 -> ex_valid=0, bubble_cnt unchanged.
REQ-034 Saturation: CNTW=2 with 5 consecutive stall edges -> bubble_cnt sequence 1, 2, 3, 3, 3.
